fw_loader: RTL

FW_LOADER -- requirements
Module: fw_loader

---
 rtl/fw_loader_pkg.sv | 8 +
 rtl/fw_loader_reset_hold_ctr.sv | 19 +
 rtl/fw_loader.sv | 79 +++++++
 3 files changed

// File: rtl/fw_loader_pkg.sv
// fw_loader_pkg: shared state encoding, reset-vector addresses and width defaults
package fw_loader_pkg;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int REG_WIDTH_DEF = 8;
  localparam logic [15:0] VEC_LO_ADDR = 16'hFFFC;
  localparam logic [15:0] VEC_HI_ADDR = 16'hFFFD;
  typedef enum logic [2:0] {IDLE, LOAD, VEC_LO, VEC_HI, HOLD, DONE, ERROR} state_t;
endpackage

// File: rtl/fw_loader_reset_hold_ctr.sv
// reset_hold_ctr: down-counter that flags when a loaded hold interval has elapsed
module reset_hold_ctr #(
  parameter int HOLD = 8
) (
  input  logic phi0,
  input  logic reset_n,
  input  logic load,
  output logic count_done
);
  localparam int CW = $clog2(HOLD + 2);
  localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD > 0 ? HOLD - 1 : 0);
  logic [CW-1:0] cnt;
  always_ff @(posedge phi0 or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= LOAD_VAL;
    else if (cnt != '0) cnt <= cnt - CW'(1);
  end
  assign count_done = cnt == '0;
endmodule

// File: rtl/fw_loader.sv
// fw_loader: streams a program into memory at BASE_ADDR, writes the reset vector, then releases the CPU
module fw_loader import fw_loader_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int REG_WIDTH = REG_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(16'h0600),
  parameter int MAX_SIZE = 256,
  parameter int RESET_HOLD = 8
) (
  input  logic                  phi0,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [REG_WIDTH-1:0]  byte_data,
  input  logic                  byte_last,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_dout,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] byte_count
);
  localparam logic [15:0] BASE16 = 16'(BASE_ADDR);
  state_t state, state_nx;
  logic take, restart, hold_done;
  logic [ADDR_WIDTH-1:0] count_nx;
  assign byte_ready = state == LOAD;
  assign busy = state inside {LOAD, VEC_LO, VEC_HI, HOLD};
  assign done = state == DONE;
  assign error = state == ERROR;
  assign cpu_reset_n = state == DONE;
  assign take = byte_valid && byte_ready;
  assign restart = start && (state inside {IDLE, DONE, ERROR});
  assign count_nx = byte_count + ADDR_WIDTH'(1);
  // byte_last wins over the size limit, so a full-size program still completes
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERROR: state_nx = start ? LOAD : state;
      LOAD: if (take) state_nx = byte_last ? VEC_LO : (count_nx == ADDR_WIDTH'(MAX_SIZE)) ? ERROR : LOAD;
      VEC_LO: state_nx = VEC_HI;
      VEC_HI: state_nx = HOLD;
      HOLD: state_nx = hold_done ? DONE : HOLD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge phi0 or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      byte_count <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_dout <= '0;
    end else begin
      state <= state_nx;
      mem_we <= take || state == VEC_LO || state == VEC_HI;
      if (take) begin
        mem_addr <= BASE_ADDR + byte_count;
        mem_dout <= byte_data;
        byte_count <= count_nx;
      end else if (state == VEC_LO) begin
        mem_addr <= ADDR_WIDTH'(VEC_LO_ADDR);
        mem_dout <= REG_WIDTH'(BASE16[7:0]);
      end else if (state == VEC_HI) begin
        mem_addr <= ADDR_WIDTH'(VEC_HI_ADDR);
        mem_dout <= REG_WIDTH'(BASE16[15:8]);
      end
      if (restart) byte_count <= '0;
    end
  end
  reset_hold_ctr #(.HOLD(RESET_HOLD)) u_hold (
    .phi0(phi0),
    .reset_n(reset_n),
    .load(state == VEC_HI),
    .count_done(hold_done)
  );
endmodule
